// File: rtl/pulse_cdc_pkg.sv
// pulse_cdc_pkg: shared FSM state type and default parameters for pulse_backlog_issuer (CNT_W, MIN_GAP, ACK_TO)
package pulse_cdc_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, GAP} pb_state_t;
  localparam int CNT_W_DEF   = 8;
  localparam int MIN_GAP_DEF = 0;
  localparam int ACK_TO_DEF  = 4;
endpackage

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt: saturating up/down counter; ports clk, rst, clr, inc, dec in; cnt[W-1:0] count out; sat_hit flags an increment dropped at all-ones
module sat_updown_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         sat_hit
);
  logic full;
  assign full    = &cnt;
  assign sat_hit = inc && !dec && full && !clr;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/pulse_backlog_issuer.sv
// pulse_backlog_issuer: backlogs event pulses and issues them one at a time to a busy-paced pulse synchronizer; ports clk, rst, evt_in, clr, sync_busy in; sync_pulse, pending_cnt[CNT_W-1:0], overflow, ack_err, idle out; PULSE_BACKLOG_STATS_EN adds issued_cnt[15:0]
module pulse_backlog_issuer
  import pulse_cdc_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int ACK_TO  = ACK_TO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             clr,
  input  logic             sync_busy,
  output logic             sync_pulse,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow,
  output logic             ack_err,
  output logic             idle
`ifdef PULSE_BACKLOG_STATS_EN
  ,
  output logic [15:0]      issued_cnt
`endif
);
  localparam int TW = 16;
  pb_state_t state, state_n;
  logic [TW-1:0] tmr;
  logic issue, accept, timeout, sat_hit;
  sat_updown_cnt #(.W(CNT_W)) u_backlog (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(evt_in),
    .dec(accept),
    .cnt(pending_cnt),
    .sat_hit(sat_hit)
  );
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE:
        if (!sync_busy && (pending_cnt != '0 || evt_in)) begin
          issue   = 1'b1;
          state_n = WAIT_ACK;
        end
      WAIT_ACK:
        if (sync_busy) begin
          accept  = 1'b1;
          state_n = WAIT_DONE;
        end else if (tmr == TW'(ACK_TO - 1)) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      WAIT_DONE:
        if (!sync_busy) state_n = (MIN_GAP > 0) ? GAP : IDLE;
      GAP:
        if (tmr == TW'(MIN_GAP - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clr) begin
      state_n = IDLE;
      issue   = 1'b0;
      accept  = 1'b0;
      timeout = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst || clr) begin
      state      <= IDLE;
      tmr        <= '0;
      sync_pulse <= 1'b0;
      overflow   <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_n;
      tmr        <= (state_n != state) ? '0 : tmr + 1'b1;
      sync_pulse <= issue;
      overflow   <= overflow | sat_hit;
      ack_err    <= ack_err | timeout;
    end
  assign idle = (state == IDLE) && (pending_cnt == '0) && !sync_busy;
`ifdef PULSE_BACKLOG_STATS_EN
  always_ff @(posedge clk)
    if (rst || clr) issued_cnt <= '0;
    else if (accept) issued_cnt <= issued_cnt + 1'b1;
`endif
endmodule
